systolic_ctrl: RTL and testbench

Sequencer for the reconfigurable systolic array of weight-stationary/output-stationary PEs. Drives the broadcast 2-bit `mode_ctrl` and `weight_clr` lines and a feed index for the input/weight buffers. Runs one complete tile job per `start`: clear, optional weight load, compute plus pipeline flush, and in OS mode a column-by-column result read. Sits between the layer-level scheduler and the PE array.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/ctrl_step_counter.sv | 43 ++++
 rtl/systolic_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

    // Controller phases of one tile job.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_COMPUTE,
        ST_READ,
        ST_DONE
    } state_e;

    // Broadcast PE mode encodings.
    localparam logic [1:0] MODE_IDLE       = 2'b00;
    localparam logic [1:0] MODE_WS_LOAD    = 2'b01;
    localparam logic [1:0] MODE_OS         = 2'b10;
    localparam logic [1:0] MODE_WS_COMPUTE = 2'b11;

    // Index width for n entries; never returns 0 so that degenerate sizes still give a legal vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ctrl_step_counter.sv
// Loadable up-counter with hold and terminal-count flag.
// One instance steps through LOAD, COMPUTE and READ in turn; the owner
// supplies the terminal value for the phase it is in.
module ctrl_step_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,      // restart from load_val (wins over advance)
    input  logic [W-1:0] load_val,
    input  logic         advance,   // step by one; low means hold (stall)
    input  logic [W-1:0] last,      // terminal value for the current phase
    output logic [W-1:0] count,
    output logic         at_last
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: load has priority, otherwise advance or hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (advance) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    // NOTE: clocked state uses <= so every flop samples pre-edge values; a blocking = here would make results depend on process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_last = (count_q == last);

endmodule

// File: rtl/systolic_ctrl.sv
// Tile-job sequencer for the reconfigurable WS/OS systolic array.
// One start runs CLEAR, LOAD (WS only), COMPUTE with pipeline flush,
// READ (OS only) and a one-cycle DONE.
// Optional feature macro: SYSTOLIC_CTRL_STALL_EN -- when defined, a low
// in_valid during LOAD or during the feeding part of COMPUTE freezes the
// array for that cycle; when undefined in_valid is ignored.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int K_WIDTH = 8,
    parameter int CNT_W   = K_WIDTH + $clog2(ROWS + COLS) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          os_mode,
    input  logic [K_WIDTH-1:0]            k_len,
    input  logic                          in_valid,
    input  logic                          out_ready,
    output logic [1:0]                    mode_ctrl,
    output logic                          weight_clr,
    output logic                          feed_en,
    output logic [CNT_W-1:0]              feed_idx,
    output logic                          sum_valid,
    output logic                          out_valid,
    output logic [idx_width(COLS)-1:0]    out_col,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned COL_W = idx_width(COLS);

    localparam logic [CNT_W-1:0] ROWS_C      = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(COLS - 1);
    // Last COMPUTE step minus k_len: WS flush is one step longer than OS.
    localparam logic [CNT_W-1:0] WS_TAIL     = CNT_W'(ROWS + COLS - 2);
    localparam logic [CNT_W-1:0] OS_TAIL     = CNT_W'(ROWS + COLS - 3);

    state_e               state_q, state_d;
    logic                 os_q, os_d;
    logic [K_WIDTH-1:0]   k_q, k_d;

    logic [CNT_W-1:0]     cnt;
    logic                 cnt_at_last;
    logic                 cnt_load;
    logic                 cnt_adv;
    logic [CNT_W-1:0]     cnt_last;

    logic [CNT_W-1:0]     k_ext;
    logic                 feeding;
    logic                 in_window;
    logic                 stall;

    assign k_ext     = CNT_W'(k_q);
    assign feeding   = (cnt < k_ext);
    assign in_window = (cnt >= ROWS_C) && (cnt < ROWS_C + k_ext);

`ifdef SYSTOLIC_CTRL_STALL_EN
    // Missing feeder data freezes the array only while data is actually being consumed.
    assign stall = !in_valid && ((state_q == ST_LOAD) || ((state_q == ST_COMPUTE) && feeding));
`else
    assign stall = 1'b0;
    logic unused_in_valid;
    assign unused_in_valid = in_valid;
`endif

    ctrl_step_counter #(
        .W (CNT_W)
    ) u_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val ('0),
        .advance  (cnt_adv),
        .last     (cnt_last),
        .count    (cnt),
        .at_last  (cnt_at_last)
    );

    // Next-state, config latch and step-counter control.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        os_d     = os_q;
        k_d      = k_q;
        cnt_load = 1'b0;
        cnt_adv  = 1'b0;
        cnt_last = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    os_d     = os_mode;
                    k_d      = (k_len == '0) ? K_WIDTH'(1) : k_len;
                    cnt_load = 1'b1;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_load = 1'b1;
                state_d  = os_q ? ST_COMPUTE : ST_LOAD;
            end
            ST_LOAD: begin
                cnt_last = LOAD_LAST;
                if (!stall) begin
                    if (cnt_at_last) begin
                        cnt_load = 1'b1;
                        state_d  = ST_COMPUTE;
                    end else begin
                        cnt_adv = 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                cnt_last = k_ext + (os_q ? OS_TAIL : WS_TAIL);
                if (!stall) begin
                    if (cnt_at_last) begin
                        cnt_load = 1'b1;
                        state_d  = os_q ? ST_READ : ST_DONE;
                    end else begin
                        cnt_adv = 1'b1;
                    end
                end
            end
            ST_READ: begin
                cnt_last = READ_LAST;
                if (out_ready) begin
                    if (cnt_at_last) begin
                        cnt_load = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_adv = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched job configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            os_q    <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            os_q    <= os_d;
            k_q     <= k_d;
        end
    end

    // Output decode from state and step count only; start never reaches an output.
    always_comb begin
        mode_ctrl  = MODE_IDLE;
        weight_clr = 1'b0;
        feed_en    = 1'b0;
        feed_idx   = '0;
        sum_valid  = 1'b0;
        out_valid  = 1'b0;
        out_col    = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy       = 1'b1;
                weight_clr = 1'b1;
            end
            ST_LOAD: begin
                busy     = 1'b1;
                feed_idx = cnt;
                if (!stall) begin
                    mode_ctrl = MODE_WS_LOAD;
                    feed_en   = 1'b1;
                end
            end
            ST_COMPUTE: begin
                busy = 1'b1;
                if (feeding) begin
                    feed_idx = cnt;
                end
                if (!stall) begin
                    mode_ctrl = os_q ? MODE_OS : MODE_WS_COMPUTE;
                    feed_en   = feeding;
                    sum_valid = !os_q && in_window;
                end
            end
            ST_READ: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_col   = cnt[COL_W-1:0];
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl (ROWS=COLS=4): directed table of
// jobs, hand-written corner sequences and randomized jobs compared cycle by
// cycle against a phase-level reference model.
module tb_systolic_ctrl;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int K_WIDTH = 8;
    localparam int CNT_W   = K_WIDTH + $clog2(ROWS + COLS) + 1;
    localparam int COL_W   = $clog2(COLS);
`ifdef SYSTOLIC_CTRL_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               os_mode;
    logic [K_WIDTH-1:0] k_len;
    logic               in_valid;
    logic               out_ready;
    logic [1:0]         mode_ctrl;
    logic               weight_clr;
    logic               feed_en;
    logic [CNT_W-1:0]   feed_idx;
    logic               sum_valid;
    logic               out_valid;
    logic [COL_W-1:0]   out_col;
    logic               busy;
    logic               done;

    systolic_ctrl #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .K_WIDTH (K_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .os_mode    (os_mode),
        .k_len      (k_len),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .mode_ctrl  (mode_ctrl),
        .weight_clr (weight_clr),
        .feed_en    (feed_en),
        .feed_idx   (feed_idx),
        .sum_valid  (sum_valid),
        .out_valid  (out_valid),
        .out_col    (out_col),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-cycle input availability, indexed by cycle number of the job.
    bit vld [0:1023];
    bit rdy [0:1023];

    typedef struct {
        logic [1:0] mode;
        bit wclr, fen, fcare, sv, ov, busy, done;
        int fidx, ocol;
    } cyc_t;

    typedef struct {
        bit os;
        int k;
        int done_cyc;
        int sv_cnt;
        int fe_cnt;
    } vec_t;

    cyc_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic cyc_t blank(input bit b);
        cyc_t c;
        c.mode = 2'b00; c.wclr = 0; c.fen = 0; c.fcare = 0; c.sv = 0;
        c.ov = 0; c.busy = b; c.done = 0; c.fidx = 0; c.ocol = 0;
        return c;
    endfunction

    function automatic cyc_t observe();
        cyc_t c;
        c.mode = mode_ctrl; c.wclr = weight_clr; c.fen = feed_en; c.fcare = 1'b1;
        c.sv = sum_valid; c.ov = out_valid; c.busy = busy; c.done = done;
        c.fidx = int'(feed_idx); c.ocol = int'(out_col);
        return c;
    endfunction

    // Packs outputs into one word; feed_idx and out_col only count where they are defined.
    function automatic logic [63:0] pack(input cyc_t c, input bit fcare, input bit ocare);
        logic [15:0] f;
        logic [3:0]  o;
        f = fcare ? 16'(c.fidx) : 16'h0;
        o = ocare ? 4'(c.ocol) : 4'h0;
        return 64'({c.mode, c.wclr, c.fen, f, c.sv, c.ov, o, c.busy, c.done});
    endfunction

    function automatic void fill(input int vpct, input int rpct);
        for (int i = 0; i < 1024; i++) begin
            vld[i] = ($urandom_range(0, 99) < vpct);
            rdy[i] = ($urandom_range(0, 99) < rpct);
        end
    endfunction

    // Reference model: walks the job phase by phase; entry i describes cycle i+1.
    function automatic void build_model(input bit os, input int k);
        cyc_t c;
        int keff, len;
        keff = (k == 0) ? 1 : k;
        len  = keff + ROWS + COLS - (os ? 2 : 1);
        exp_q.delete();
        c = blank(1); c.wclr = 1; exp_q.push_back(c);
        if (!os) begin
            for (int s = 0; s < ROWS; s++) begin
                while (STALL_EN && !vld[exp_q.size() + 1] && exp_q.size() < 1000) begin
                    c = blank(1); c.fidx = s; c.fcare = 1; exp_q.push_back(c);
                end
                c = blank(1); c.mode = 2'b01; c.fen = 1; c.fidx = s; c.fcare = 1;
                exp_q.push_back(c);
            end
        end
        for (int s = 0; s < len; s++) begin
            while (STALL_EN && (s < keff) && !vld[exp_q.size() + 1] && exp_q.size() < 1000) begin
                exp_q.push_back(blank(1));
            end
            c = blank(1);
            c.mode  = os ? 2'b10 : 2'b11;
            c.fen   = (s < keff);
            c.fcare = (s < keff);
            c.fidx  = s;
            c.sv    = !os && (s >= ROWS) && (s <= ROWS + keff - 1);
            exp_q.push_back(c);
        end
        if (os) begin
            for (int col = 0; col < COLS; col++) begin
                do begin
                    c = blank(1); c.ov = 1; c.ocol = col; exp_q.push_back(c);
                end while (!rdy[exp_q.size()] && exp_q.size() < 1000);
            end
        end
        c = blank(0); c.done = 1; exp_q.push_back(c);
        exp_q.push_back(blank(0));
    endfunction

    // Runs one job from an idle DUT, comparing every cycle with the model.
    task automatic run_job(input string tag, input bit os, input int k, input bit noisy,
                           output int done_cyc, output int sv_cnt, output int fe_cnt);
        cyc_t e, a;
        build_model(os, k);
        done_cyc = -1; sv_cnt = 0; fe_cnt = 0;
        @(negedge clk);
        start = 1'b1; os_mode = os; k_len = K_WIDTH'(k); in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            start     = (noisy && i < exp_q.size() - 1) ? 1'($urandom) : 1'b0;
            os_mode   = noisy ? 1'($urandom) : os;
            k_len     = noisy ? K_WIDTH'($urandom) : K_WIDTH'(k);
            in_valid  = vld[i + 1];
            out_ready = rdy[i + 1];
            @(negedge clk);
            e = exp_q[i];
            a = observe();
            check($sformatf("%s cyc%0d", tag, i + 1), pack(a, e.fcare, e.ov), pack(e, e.fcare, e.ov));
            if (done && done_cyc < 0) done_cyc = i + 1;
            if (sum_valid) sv_cnt++;
            if (feed_en) fe_cnt++;
        end
    endtask

    vec_t vecs[8];

    initial begin
        int dc, sc, fc;
        rst_n = 1'b0; start = 1'b0; os_mode = 1'b0; k_len = '0;
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset held with random inputs: everything stays zero.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            start = 1'($urandom); os_mode = 1'($urandom); k_len = K_WIDTH'($urandom);
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            @(negedge clk);
            check($sformatf("reset_hold %0d", i), pack(observe(), 1, 1), 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle_after_reset %0d", i), pack(observe(), 1, 1), 64'h0);
        end

        // Directed table: {os, k_len, done cycle, sum_valid cycles, feed_en cycles}.
        vecs[0] = '{0, 3,   16,  3,   7};
        vecs[1] = '{1, 5,   17,  0,   5};
        vecs[2] = '{0, 0,   14,  1,   5};
        vecs[3] = '{0, 1,   14,  1,   5};
        vecs[4] = '{1, 0,   13,  0,   1};
        vecs[5] = '{1, 1,   13,  0,   1};
        vecs[6] = '{0, 9,   22,  9,   13};
        vecs[7] = '{0, 255, 268, 255, 259};
        for (int v = 0; v < 8; v++) begin
            fill(100, 100);
            run_job($sformatf("vec%0d", v), vecs[v].os, vecs[v].k, 1'b0, dc, sc, fc);
            check($sformatf("vec%0d done_cycle", v), 64'(dc), 64'(vecs[v].done_cyc));
            check($sformatf("vec%0d sum_valid_count", v), 64'(sc), 64'(vecs[v].sv_cnt));
            check($sformatf("vec%0d feed_en_count", v), 64'(fc), 64'(vecs[v].fe_cnt));
        end

        // OS backpressure: out_ready low for three cycles while column 1 is offered.
        fill(100, 100);
        rdy[14] = 0; rdy[15] = 0; rdy[16] = 0;
        run_job("os_backpressure", 1'b1, 5, 1'b0, dc, sc, fc);
        check("os_backpressure done_cycle", 64'(dc), 64'd20);

        // in_valid low for two cycles at LOAD step 2.
        fill(100, 100);
        vld[4] = 0; vld[5] = 0;
        run_job("load_stall", 1'b0, 3, 1'b0, dc, sc, fc);
`ifdef SYSTOLIC_CTRL_STALL_EN
        check("load_stall done_cycle", 64'(dc), 64'd18);
`else
        check("load_stall done_cycle", 64'(dc), 64'd16);
`endif

        // Reset pulse in the middle of COMPUTE.
        fill(100, 100);
        @(negedge clk);
        start = 1'b1; os_mode = 1'b0; k_len = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("midjob mode before reset", 64'(mode_ctrl), 64'h3);
        rst_n = 1'b0;
        #1;
        check("midjob async reset outputs", pack(observe(), 1, 1), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("after_midjob_reset %0d", i), 64'({done, busy, mode_ctrl}), 64'h0);
        end

        // Randomized jobs with noisy start/config inputs and random handshakes.
        for (int j = 0; j < 20; j++) begin
            bit os;
            int k;
            os = 1'($urandom);
            k  = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 12);
            fill($urandom_range(50, 100), $urandom_range(40, 100));
            run_job($sformatf("rand%0d", j), os, k, 1'b1, dc, sc, fc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
